// File: rtl/wakeup_rs_pkg.sv
// Shared sizing, RS location type and latency helper for the wakeup array.
package wakeup_rs_pkg;

    localparam int RS_ENTRIES    = 16;
    localparam int NUM_FUS       = 4;
    localparam int FU_IDX_WIDTH  = $clog2(NUM_FUS);
    localparam int COL_IDX_WIDTH = $clog2(RS_ENTRIES);
    localparam int LAT_WIDTH     = 4;
    localparam int LOC_WIDTH     = FU_IDX_WIDTH + COL_IDX_WIDTH;

    localparam logic [LAT_WIDTH-1:0] LAT_UNKNOWN = '1;

    typedef struct packed {
        logic [FU_IDX_WIDTH-1:0]  fu;
        logic [COL_IDX_WIDTH-1:0] col;
    } rs_loc_t;

    // Countdown start value: a latency of 0 behaves like 1.
    function automatic logic [LAT_WIDTH-1:0] wake_cnt(input logic [LAT_WIDTH-1:0] lat);
        return (lat == '0) ? '0 : lat - 1'b1;
    endfunction

endpackage

// File: rtl/wakeup_rs_src_tracker.sv
// One source operand's producer tracking: pending/counting state, wakeup match and countdown.
module wakeup_rs_src_tracker
    import wakeup_rs_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             alloc,
    input  logic                             dp_en,
    input  rs_loc_t                          dp_loc,
    input  logic [NUM_FUS-1:0]               wake_valid,
    input  logic [NUM_FUS*COL_IDX_WIDTH-1:0] wake_col,
    input  logic [NUM_FUS*LAT_WIDTH-1:0]     wake_lat,
    input  logic                             mem_wake_valid,
    input  rs_loc_t                          mem_wake_loc,
    output logic                             ready
);

    logic                 pending_q, pending_d;
    logic                 counting_q, counting_d;
    logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
    rs_loc_t              loc_q, loc_d;
    logic                 bc_hit;
    logic [LAT_WIDTH-1:0] bc_lat;

    always_comb begin
        // A dispatching source is evaluated as if already resident, so it sees this cycle's wakeups.
        loc_d      = alloc ? dp_loc : loc_q;
        pending_d  = alloc ? dp_en : pending_q;
        counting_d = alloc ? 1'b0 : counting_q;
        cnt_d      = alloc ? '0 : cnt_q;

        bc_hit = 1'b0;
        bc_lat = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (wake_valid[f] && loc_d.fu == FU_IDX_WIDTH'(f) &&
                wake_col[f*COL_IDX_WIDTH +: COL_IDX_WIDTH] == loc_d.col) begin
                bc_hit = 1'b1;
                bc_lat = wake_lat[f*LAT_WIDTH +: LAT_WIDTH];
            end
        end

        if (pending_d && !counting_d) begin
            if (bc_hit && bc_lat != LAT_UNKNOWN) begin
                counting_d = 1'b1;
                cnt_d      = wake_cnt(bc_lat);
            end else if (mem_wake_valid && mem_wake_loc == loc_d) begin
                pending_d = 1'b0;
            end
        end else if (counting_d && cnt_d != '0) begin
            cnt_d = cnt_d - 1'b1;
        end

        if (flush) begin
            pending_d  = 1'b0;
            counting_d = 1'b0;
            cnt_d      = '0;
            loc_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= 1'b0;
            counting_q <= 1'b0;
            cnt_q      <= '0;
            loc_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            counting_q <= counting_d;
            cnt_q      <= cnt_d;
            loc_q      <= loc_d;
        end
    end

    assign ready = ~pending_q | (counting_q & (cnt_q == '0));

endmodule

// File: rtl/wakeup_rs.sv
// Per-pipe reservation-station wakeup array: allocation, source wakeup tracking, ready requests.
module wakeup_rs
    import wakeup_rs_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              dispatch_valid,
    input  logic [LAT_WIDTH-1:0]              latency_in,
    input  logic                              src1_dp_en,
    input  logic [LOC_WIDTH-1:0]              src1_dp_loc,
    input  logic                              src2_dp_en,
    input  logic [LOC_WIDTH-1:0]              src2_dp_loc,
    output logic                              entry_free,
    output logic [COL_IDX_WIDTH-1:0]          entry_index,
    input  logic [NUM_FUS-1:0]                wake_valid,
    input  logic [NUM_FUS*COL_IDX_WIDTH-1:0]  wake_col,
    input  logic [NUM_FUS*LAT_WIDTH-1:0]      wake_lat,
    input  logic                              mem_wake_valid,
    input  logic [LOC_WIDTH-1:0]              mem_wake_loc,
    output logic [RS_ENTRIES-1:0]             req_vec,
    input  logic                              grant_valid,
    input  logic [COL_IDX_WIDTH-1:0]          grant_index,
    output logic [RS_ENTRIES*LAT_WIDTH-1:0]   entry_lat
);

    logic [RS_ENTRIES-1:0]                valid_q, valid_d;
    logic [RS_ENTRIES-1:0][LAT_WIDTH-1:0] lat_q, lat_d;
    logic [RS_ENTRIES-1:0]                alloc_vec;
    logic [RS_ENTRIES-1:0]                src1_rdy, src2_rdy;
    logic                                 alloc;

    always_comb begin
        entry_free  = 1'b0;
        entry_index = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                entry_free  = 1'b1;
                entry_index = COL_IDX_WIDTH'(i);
            end
        end
    end

    assign alloc = dispatch_valid & entry_free & ~flush;

    always_comb begin
        alloc_vec = '0;
        valid_d   = valid_q;
        lat_d     = lat_q;
        if (alloc) begin
            alloc_vec[entry_index] = 1'b1;
            valid_d[entry_index]   = 1'b1;
            lat_d[entry_index]     = latency_in;
        end
        // The granted entry is still valid this cycle, so the encoder cannot hand it out again.
        if (grant_valid && valid_q[grant_index]) begin
            valid_d[grant_index] = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
            lat_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lat_q   <= lat_d;
        end
    end

    for (genvar e = 0; e < RS_ENTRIES; e++) begin : g_entry
        wakeup_rs_src_tracker u_src1 (
            .clk            (clk),
            .rst            (rst),
            .flush          (flush),
            .alloc          (alloc_vec[e]),
            .dp_en          (src1_dp_en),
            .dp_loc         (src1_dp_loc),
            .wake_valid     (wake_valid),
            .wake_col       (wake_col),
            .wake_lat       (wake_lat),
            .mem_wake_valid (mem_wake_valid),
            .mem_wake_loc   (mem_wake_loc),
            .ready          (src1_rdy[e])
        );

        wakeup_rs_src_tracker u_src2 (
            .clk            (clk),
            .rst            (rst),
            .flush          (flush),
            .alloc          (alloc_vec[e]),
            .dp_en          (src2_dp_en),
            .dp_loc         (src2_dp_loc),
            .wake_valid     (wake_valid),
            .wake_col       (wake_col),
            .wake_lat       (wake_lat),
            .mem_wake_valid (mem_wake_valid),
            .mem_wake_loc   (mem_wake_loc),
            .ready          (src2_rdy[e])
        );
    end

    assign req_vec   = valid_q & src1_rdy & src2_rdy;
    assign entry_lat = lat_q;

    a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (rst)
        !(dispatch_valid && !entry_free && !flush));

    a_grant_to_valid_entry: assert property (@(posedge clk) disable iff (rst)
        !(grant_valid && !flush && !valid_q[grant_index]));

endmodule

// File: tb/tb_wakeup_rs.sv
// Directed bench for wakeup_rs: allocation, latency countdown, unknown-latency wake, bypass, grant, flush, reset.
module tb_wakeup_rs;
    import wakeup_rs_pkg::*;

    logic                             clk;
    logic                             rst;
    logic                             flush;
    logic                             dispatch_valid;
    logic [LAT_WIDTH-1:0]             latency_in;
    logic                             src1_dp_en;
    logic [LOC_WIDTH-1:0]             src1_dp_loc;
    logic                             src2_dp_en;
    logic [LOC_WIDTH-1:0]             src2_dp_loc;
    logic                             entry_free;
    logic [COL_IDX_WIDTH-1:0]         entry_index;
    logic [NUM_FUS-1:0]               wake_valid;
    logic [NUM_FUS*COL_IDX_WIDTH-1:0] wake_col;
    logic [NUM_FUS*LAT_WIDTH-1:0]     wake_lat;
    logic                             mem_wake_valid;
    logic [LOC_WIDTH-1:0]             mem_wake_loc;
    logic [RS_ENTRIES-1:0]            req_vec;
    logic                             grant_valid;
    logic [COL_IDX_WIDTH-1:0]         grant_index;
    logic [RS_ENTRIES*LAT_WIDTH-1:0]  entry_lat;

    int tests_run;
    int tests_failed;

    wakeup_rs dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .latency_in     (latency_in),
        .src1_dp_en     (src1_dp_en),
        .src1_dp_loc    (src1_dp_loc),
        .src2_dp_en     (src2_dp_en),
        .src2_dp_loc    (src2_dp_loc),
        .entry_free     (entry_free),
        .entry_index    (entry_index),
        .wake_valid     (wake_valid),
        .wake_col       (wake_col),
        .wake_lat       (wake_lat),
        .mem_wake_valid (mem_wake_valid),
        .mem_wake_loc   (mem_wake_loc),
        .req_vec        (req_vec),
        .grant_valid    (grant_valid),
        .grant_index    (grant_index),
        .entry_lat      (entry_lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        latency_in     = '0;
        src1_dp_en     = 1'b0;
        src1_dp_loc    = '0;
        src2_dp_en     = 1'b0;
        src2_dp_loc    = '0;
        wake_valid     = '0;
        wake_col       = '0;
        wake_lat       = '0;
        mem_wake_valid = 1'b0;
        mem_wake_loc   = '0;
        grant_valid    = 1'b0;
        grant_index    = '0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (entry_free !== 1'b1) begin tests_failed++; $display("FAIL reset_free: got %b expected 1", entry_free); end
        tests_run++;
        if (entry_index !== 4'd0) begin tests_failed++; $display("FAIL reset_index: got %0d expected 0", entry_index); end
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL reset_req: got %h expected 0000", req_vec); end
        tests_run++;
        if (entry_lat !== 64'h0) begin tests_failed++; $display("FAIL reset_lat: got %h expected 0", entry_lat); end
    endtask

    task automatic test_dispatch_basic();
        dispatch_valid = 1'b1;
        latency_in     = 4'd1;
        #1;
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL basic_no_same_cycle_req: got %h expected 0000", req_vec); end
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL basic_req: got %h expected 0001", req_vec); end
        tests_run++;
        if (entry_index !== 4'd1) begin tests_failed++; $display("FAIL basic_index: got %0d expected 1", entry_index); end
        tests_run++;
        if (entry_lat !== 64'h1) begin tests_failed++; $display("FAIL basic_lat: got %h expected 1", entry_lat); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000 || entry_index !== 4'd0) begin
            tests_failed++; $display("FAIL basic_grant: got req %h idx %0d expected req 0000 idx 0", req_vec, entry_index);
        end
    endtask

    task automatic test_latency_countdown();
        dispatch_valid = 1'b1;
        latency_in     = 4'd2;
        src1_dp_en     = 1'b1;
        src1_dp_loc    = 6'h25;
        tick();
        idle_inputs();
        // Right column on the wrong pipe must not wake the source.
        wake_valid     = 4'b0010;
        wake_col[7:4]  = 4'd5;
        wake_lat[7:4]  = 4'd1;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL lat_wrong_fu: got %h expected 0000", req_vec); end
        wake_valid     = 4'b0100;
        wake_col[11:8] = 4'd5;
        wake_lat[11:8] = 4'd3;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL lat_t_plus_1: got %h expected 0000", req_vec); end
        tick();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL lat_t_plus_2: got %h expected 0000", req_vec); end
        tick();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL lat_t_plus_3: got %h expected 0001", req_vec); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_wake();
        dispatch_valid = 1'b1;
        latency_in     = 4'hF;
        src2_dp_en     = 1'b1;
        src2_dp_loc    = 6'h39;
        tick();
        idle_inputs();
        wake_valid      = 4'b1000;
        wake_col[15:12] = 4'd9;
        wake_lat[15:12] = 4'hF;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL mem_unknown_lat_bcast: got %h expected 0000", req_vec); end
        mem_wake_valid = 1'b1;
        mem_wake_loc   = 6'h38;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL mem_wrong_loc: got %h expected 0000", req_vec); end
        mem_wake_valid = 1'b1;
        mem_wake_loc   = 6'h39;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL mem_match: got %h expected 0001", req_vec); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
    endtask

    task automatic test_bypass();
        dispatch_valid = 1'b1;
        latency_in     = 4'd1;
        src1_dp_en     = 1'b1;
        src1_dp_loc    = 6'h13;
        wake_valid     = 4'b0010;
        wake_col[7:4]  = 4'd3;
        wake_lat[7:4]  = 4'd1;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL bypass_bcast: got %h expected 0001", req_vec); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
        dispatch_valid = 1'b1;
        src1_dp_en     = 1'b1;
        src1_dp_loc    = 6'h34;
        mem_wake_valid = 1'b1;
        mem_wake_loc   = 6'h34;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL bypass_mem: got %h expected 0001", req_vec); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
    endtask

    task automatic test_same_producer();
        dispatch_valid = 1'b1;
        src1_dp_en     = 1'b1;
        src1_dp_loc    = 6'h02;
        src2_dp_en     = 1'b1;
        src2_dp_loc    = 6'h02;
        tick();
        idle_inputs();
        wake_valid    = 4'b0001;
        wake_col[3:0] = 4'd2;
        wake_lat[3:0] = 4'd2;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL same_prod_early: got %h expected 0000", req_vec); end
        tick();
        tests_run++;
        if (req_vec !== 16'h0001) begin tests_failed++; $display("FAIL same_prod_ready: got %h expected 0001", req_vec); end
        grant_valid = 1'b1;
        grant_index = 4'd0;
        tick();
        idle_inputs();
    endtask

    task automatic test_fill_grant();
        for (int i = 0; i < RS_ENTRIES; i++) begin
            dispatch_valid = 1'b1;
            latency_in     = LAT_WIDTH'(i);
            #1;
            tests_run++;
            if (entry_index !== COL_IDX_WIDTH'(i)) begin
                tests_failed++; $display("FAIL fill_index_%0d: got %0d expected %0d", i, entry_index, i);
            end
            tick();
        end
        idle_inputs();
        tests_run++;
        if (entry_free !== 1'b0 || entry_index !== 4'd0) begin
            tests_failed++; $display("FAIL fill_full: got free %b idx %0d expected free 0 idx 0", entry_free, entry_index);
        end
        tests_run++;
        if (req_vec !== 16'hFFFF) begin tests_failed++; $display("FAIL fill_req: got %h expected ffff", req_vec); end
        tests_run++;
        if (entry_lat !== 64'hFEDCBA9876543210) begin
            tests_failed++; $display("FAIL fill_lat: got %h expected fedcba9876543210", entry_lat);
        end
        grant_valid = 1'b1;
        grant_index = 4'd7;
        tick();
        idle_inputs();
        tests_run++;
        if (entry_free !== 1'b1 || entry_index !== 4'd7) begin
            tests_failed++; $display("FAIL grant7_free: got free %b idx %0d expected free 1 idx 7", entry_free, entry_index);
        end
        tests_run++;
        if (req_vec !== 16'hFF7F) begin tests_failed++; $display("FAIL grant7_req: got %h expected ff7f", req_vec); end
        grant_valid    = 1'b1;
        grant_index    = 4'd3;
        dispatch_valid = 1'b1;
        latency_in     = 4'hA;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'hFFF7 || entry_index !== 4'd3) begin
            tests_failed++; $display("FAIL grant_dispatch_same_cycle: got req %h idx %0d expected req fff7 idx 3", req_vec, entry_index);
        end
        tests_run++;
        if (entry_lat[31:28] !== 4'hA) begin tests_failed++; $display("FAIL realloc_lat: got %h expected a", entry_lat[31:28]); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000 || entry_free !== 1'b1) begin
            tests_failed++; $display("FAIL flush_full_array: got req %h free %b expected req 0000 free 1", req_vec, entry_free);
        end
        for (int i = 0; i < 5; i++) begin
            dispatch_valid = 1'b1;
            tick();
        end
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h001F) begin tests_failed++; $display("FAIL flush_prefill: got %h expected 001f", req_vec); end
        flush          = 1'b1;
        dispatch_valid = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0000 || entry_index !== 4'd0 || entry_free !== 1'b1) begin
            tests_failed++; $display("FAIL flush_with_dispatch: got req %h idx %0d free %b expected req 0000 idx 0 free 1", req_vec, entry_index, entry_free);
        end
    endtask

    task automatic test_async_reset();
        dispatch_valid = 1'b1;
        latency_in     = 4'd3;
        src1_dp_en     = 1'b1;
        src1_dp_loc    = 6'h21;
        tick();
        idle_inputs();
        dispatch_valid = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (req_vec !== 16'h0002) begin tests_failed++; $display("FAIL areset_setup: got %h expected 0002", req_vec); end
        wake_valid     = 4'b0100;
        wake_col[11:8] = 4'd1;
        wake_lat[11:8] = 4'd6;
        tick();
        idle_inputs();
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (req_vec !== 16'h0000 || entry_free !== 1'b1 || entry_index !== 4'd0) begin
            tests_failed++; $display("FAIL areset_immediate: got req %h free %b idx %0d expected req 0000 free 1 idx 0", req_vec, entry_free, entry_index);
        end
        tests_run++;
        if (entry_lat !== 64'h0) begin tests_failed++; $display("FAIL areset_lat: got %h expected 0", entry_lat); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (req_vec !== 16'h0000) begin tests_failed++; $display("FAIL areset_no_residue: got %h expected 0000", req_vec); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_dispatch_basic();
        test_latency_countdown();
        test_mem_wake();
        test_bypass();
        test_same_producer();
        test_fill_grant();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
